io_output_arbiter: RTL and testbench
====================================

Name: io_output_arbiter

Overview:
- Shares the memory-mapped output-port register bank between two write requesters: the CPU store path and an auxiliary master (debug/loader).
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a single registered write strobe (wr_addr/wr_data/wr_en) that drives the output register bank.
- Writes to addresses outside the output-port window are consumed, dropped and counted.

Parameters:
- PORT_BASE, 6'b100000, word index (addr[7:2]) of output port 0.
- NUM_PORTS, 2, number of consecutive output-port words in the window.
- DROP_W, 8, width of the saturating dropped-write counter.

Ports:
- io_clk  input  1  clock; all state updates on the rising edge.
- clm  input  1  reset; synchronous, active-high.
- cpu_valid  input  1  CPU write request valid.
- cpu_ready  output  1  CPU holding buffer empty; transfer when cpu_valid & cpu_ready at the edge.
- cpu_addr  input  32  CPU write byte address.
- cpu_data  input  32  CPU write data.
- aux_valid  input  1  auxiliary write request valid.
- aux_ready  output  1  auxiliary holding buffer empty.
- aux_addr  input  32  auxiliary write byte address.
- aux_data  input  32  auxiliary write data.
- wr_en  output  1  registered one-cycle write strobe to the output register bank.
- wr_addr  output  32  registered write address.
- wr_data  output  32  registered write data.
- grant_id  output  1  requester of the last serviced entry (0=CPU, 1=aux), valid or dropped.
- drop_cnt  output  DROP_W  saturating count of dropped out-of-window writes.
- busy  output  1  either holding buffer full.

Behaviour:
- Reset, when clm=1 at an edge:
  - both buffers empty; cpu_ready=aux_ready=1 in the following cycle.
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0, drop_cnt=0, busy=0.
  - round-robin pointer set so the CPU wins the first tie.
- Reset mid-operation: buffered entries are discarded with no write issued. A clm=1 edge overrides any simultaneous handshake or grant.
- Ready: cpu_ready = ~cpu_full and aux_ready = ~aux_full, taken from registered state only (no combinational path from valid).
- Capture: at an edge with valid & ready, the buffer loads addr/data and sets full.
- Arbitration, at each edge using the full flags registered before that edge:
  - Neither full: no grant; wr_en<=0; wr_addr/wr_data hold.
  - Exactly one full: grant that requester.
  - Both full: grant the requester not granted last; the pointer updates on every grant.
- Service of the granted entry, on the same edge:
  - buffer cleared; grant_id <= requester.
  - In window, i.e. PORT_BASE <= addr[7:2] <= PORT_BASE+NUM_PORTS-1: wr_en<=1, wr_addr<=addr, wr_data<=data.
  - Out of window: wr_en<=0, wr_addr/wr_data hold, drop_cnt increments and saturates at all-ones.
- Latency: handshake at edge N; wr_en high during the cycle after edge N+1. wr_en is never high for two cycles for the same entry.
- Throughput:
  - a single requester completes one transfer per 2 cycles, since ready is low in the cycle after capture.
  - two saturating requesters alternate, giving one write per cycle.
- Freshly captured entries are not granted at their capture edge.
- addr[31:8] and addr[1:0] are ignored by the window check and passed through unchanged in wr_addr.
- busy = cpu_full | aux_full.

Decomposition:
- Package io_arb_pkg:
  - constants PORT_BASE_DEF, NUM_PORTS_DEF, REQ_CPU=1'b0, REQ_AUX=1'b1.
  - function in_window(addr) returning the addr[7:2] window check.
- Sub-module io_req_buffer: one-entry holding buffer with valid/ready in, a clear input and full/addr/data out. Instantiated twice; the arbiter, counter and output registers live in the top.

Test Plan:
- Reset:
  - assert clm for 2 cycles with cpu_valid=1 pending -> wr_en=0, drop_cnt=0, cpu_ready=1 after release.
  - no write from the discarded request.
- CPU single write:
  - cpu_valid with addr=0x80, data=0x12345678 at edge N -> wr_en=1 for exactly one cycle after edge N+1, wr_addr=0x80, wr_data=0x12345678, grant_id=0.
  - cpu_ready=0 for one cycle.
- Tie after reset:
  - CPU addr 0x84/data 0xA and aux addr 0x80/data 0xB both captured at edge N -> CPU write after edge N+1, aux write after edge N+2.
  - grant_id sequence 0,1.
- Sustained contention:
  - both requesters hold valid=1 with in-window addresses for 20 cycles -> writes strictly alternate CPU/aux with no idle cycles after the first.
- Out-of-window:
  - aux writes addr=0x88 then addr=0x7C -> no wr_en, drop_cnt=2, wr_addr/wr_data unchanged.
  - with DROP_W=2, five drops -> drop_cnt=3.
- Reset mid-operation:
  - aux entry captured at edge N, clm=1 at edge N+1 -> no wr_en, aux_ready=1 after release.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types, constants and the output-port window check for the I/O output arbiter.
package io_arb_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam logic [5:0]  PORT_BASE_DEF = 6'b100000;
    localparam int unsigned NUM_PORTS_DEF = 2;
    localparam int unsigned DROP_W_DEF    = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Word index addr[7:2] must fall in [base, base+num-1]; other address bits are ignored.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [5:0]        base,
                                       input int unsigned       num);
        int unsigned idx;
        int unsigned lo;
        idx = 32'(addr[7:2]);
        lo  = 32'(base);
        return (idx >= lo) && (idx < lo + num);
    endfunction

endpackage

// File: rtl/io_req_buffer.sv
// One-entry holding buffer: accepts a write on valid & ready, holds it until cleared by the arbiter.
module io_req_buffer
    import io_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    valid,
    input  wr_req_t req_in,
    input  logic    clear,
    output logic    ready,
    output logic    full,
    output logic    full_next,
    output wr_req_t req_out
);

    logic    full_q;
    logic    full_d;
    wr_req_t req_q;
    wr_req_t req_d;

    // Load only when empty, so a clear and a load can never coincide.
    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (clear) begin
            full_d = 1'b0;
        end
        if (valid && !full_q) begin
            full_d = 1'b1;
            req_d  = req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign ready     = ~full_q;
    assign full      = full_q;
    assign full_next = full_d;
    assign req_out   = req_q;

endmodule

// File: rtl/io_output_arbiter.sv
// Round-robin arbiter draining CPU and auxiliary write buffers into one registered
// output-port write strobe; out-of-window writes are dropped and counted.
module io_output_arbiter
    import io_arb_pkg::*;
#(
    parameter logic [5:0]  PORT_BASE = PORT_BASE_DEF,
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DROP_W    = DROP_W_DEF
) (
    input  logic              io_clk,
    input  logic              clm,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              grant_id,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    logic    cpu_full;
    logic    aux_full;
    logic    cpu_full_next;
    logic    aux_full_next;
    wr_req_t cpu_req;
    wr_req_t aux_req;
    wr_req_t cpu_in;
    wr_req_t aux_in;
    logic    cpu_gnt;
    logic    aux_gnt;
    wr_req_t sel_req;

    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              grant_id_q, grant_id_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              busy_q,     busy_d;
    logic              rr_last_q,  rr_last_d;

    assign cpu_in = '{addr: cpu_addr, data: cpu_data};
    assign aux_in = '{addr: aux_addr, data: aux_data};

    io_req_buffer u_cpu_buf (
        .clk       (io_clk),
        .rst       (clm),
        .valid     (cpu_valid),
        .req_in    (cpu_in),
        .clear     (cpu_gnt),
        .ready     (cpu_ready),
        .full      (cpu_full),
        .full_next (cpu_full_next),
        .req_out   (cpu_req)
    );

    io_req_buffer u_aux_buf (
        .clk       (io_clk),
        .rst       (clm),
        .valid     (aux_valid),
        .req_in    (aux_in),
        .clear     (aux_gnt),
        .ready     (aux_ready),
        .full      (aux_full),
        .full_next (aux_full_next),
        .req_out   (aux_req)
    );

    // On a tie the requester that was not granted last wins.
    assign cpu_gnt = cpu_full && (!aux_full || (rr_last_q == REQ_AUX));
    assign aux_gnt = aux_full && !cpu_gnt;
    assign sel_req = cpu_gnt ? cpu_req : aux_req;

    always_comb begin
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        drop_cnt_d = drop_cnt_q;
        rr_last_d  = rr_last_q;
        busy_d     = cpu_full_next | aux_full_next;
        if (cpu_gnt || aux_gnt) begin
            grant_id_d = aux_gnt ? REQ_AUX : REQ_CPU;
            rr_last_d  = aux_gnt ? REQ_AUX : REQ_CPU;
            if (in_window(sel_req.addr, PORT_BASE, NUM_PORTS)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_req.addr;
                wr_data_d = sel_req.data;
            end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // rr_last resets to AUX so the CPU wins the first tie.
    always_ff @(posedge io_clk) begin
        if (clm) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= REQ_CPU;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
            rr_last_q  <= REQ_AUX;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
            rr_last_q  <= rr_last_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_io_output_arbiter.sv
// Directed bench for io_output_arbiter; a second instance with DROP_W=2 checks counter saturation.
module tb_io_output_arbiter;

    logic        io_clk = 1'b0;
    logic        clm;
    logic        cpu_valid, aux_valid;
    logic [31:0] cpu_addr, cpu_data, aux_addr, aux_data;
    logic        cpu_ready, aux_ready, wr_en, grant_id, busy;
    logic [31:0] wr_addr, wr_data;
    logic [7:0]  drop_cnt;
    logic        d2_cpu_ready, d2_aux_ready, d2_wr_en, d2_grant_id, d2_busy;
    logic [31:0] d2_wr_addr, d2_wr_data;
    logic [1:0]  d2_drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 io_clk = ~io_clk;

    io_output_arbiter u_dut (
        .io_clk(io_clk), .clm(clm),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .grant_id(grant_id), .drop_cnt(drop_cnt), .busy(busy)
    );

    io_output_arbiter #(.DROP_W(2)) u_dut2 (
        .io_clk(io_clk), .clm(clm),
        .cpu_valid(cpu_valid), .cpu_ready(d2_cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .aux_valid(aux_valid), .aux_ready(d2_aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
        .wr_en(d2_wr_en), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
        .grant_id(d2_grant_id), .drop_cnt(d2_drop_cnt), .busy(d2_busy)
    );

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic test_reset();
        clm = 1'b1; cpu_valid = 1'b1; cpu_addr = 32'h80; cpu_data = 32'h55;
        aux_valid = 1'b0; aux_addr = 32'h0; aux_data = 32'h0;
        tick(); tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0h exp=0", wr_en); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0h exp=0", drop_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        clm = 1'b0; cpu_valid = 1'b0;
        tick();
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_cpu_ready got=%0h exp=1", cpu_ready); end
        checks++; if (aux_ready !== 1'b1) begin failures++; $display("FAIL rst_aux_ready got=%0h exp=1", aux_ready); end
        checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            failures++; $display("FAIL rst_wr_bus got=%h/%h exp=0/0", wr_addr, wr_data);
        end
        checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL rst_grant got=%0h exp=0", grant_id); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_discard got=%0h exp=0", wr_en); end
    endtask

    task automatic test_cpu_single();
        cpu_valid = 1'b1; cpu_addr = 32'h80; cpu_data = 32'h12345678;
        tick();
        cpu_valid = 1'b0;
        checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL single_ready_low got=%0h exp=0", cpu_ready); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_early got=%0h exp=0", wr_en); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0h exp=1", busy); end
        tick();
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%0h exp=1", wr_en); end
        checks++; if (wr_addr !== 32'h80) begin failures++; $display("FAIL single_addr got=%h exp=80", wr_addr); end
        checks++; if (wr_data !== 32'h12345678) begin failures++; $display("FAIL single_data got=%h exp=12345678", wr_data); end
        checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL single_grant got=%0h exp=0", grant_id); end
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL single_ready_back got=%0h exp=1", cpu_ready); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%0h exp=0", wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0h exp=0", busy); end
    endtask

    task automatic test_passthrough();
        cpu_valid = 1'b1; cpu_addr = 32'hABCD0185; cpu_data = 32'hCAFEF00D;
        tick();
        cpu_valid = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL pass_wr_en got=%0h exp=1", wr_en); end
        checks++; if (wr_addr !== 32'hABCD0185) begin failures++; $display("FAIL pass_addr got=%h exp=abcd0185", wr_addr); end
        checks++; if (wr_data !== 32'hCAFEF00D) begin failures++; $display("FAIL pass_data got=%h exp=cafef00d", wr_data); end
        tick();
    endtask

    task automatic test_tie();
        clm = 1'b1;
        tick();
        clm = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 32'h84; cpu_data = 32'hA;
        aux_valid = 1'b1; aux_addr = 32'h80; aux_data = 32'hB;
        tick();
        cpu_valid = 1'b0; aux_valid = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b1 || grant_id !== 1'b0 || wr_addr !== 32'h84 || wr_data !== 32'hA) begin
            failures++; $display("FAIL tie_first got=en%0h g%0h %h/%h exp=en1 g0 84/a", wr_en, grant_id, wr_addr, wr_data);
        end
        tick();
        checks++; if (wr_en !== 1'b1 || grant_id !== 1'b1 || wr_addr !== 32'h80 || wr_data !== 32'hB) begin
            failures++; $display("FAIL tie_second got=en%0h g%0h %h/%h exp=en1 g1 80/b", wr_en, grant_id, wr_addr, wr_data);
        end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL tie_done got=%0h exp=0", wr_en); end
    endtask

    task automatic test_contention();
        logic        exp_aux;
        logic [31:0] exp_data;
        cpu_valid = 1'b1; cpu_addr = 32'h80; cpu_data = 32'h1111;
        aux_valid = 1'b1; aux_addr = 32'h84; aux_data = 32'h2222;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i >= 1) begin
                exp_aux  = ((i - 1) % 2) == 1;
                exp_data = exp_aux ? 32'h2222 : 32'h1111;
                checks++; if (wr_en !== 1'b1 || grant_id !== exp_aux || wr_data !== exp_data) begin
                    failures++;
                    $display("FAIL contend_%0d got=en%0h g%0h d%h exp=en1 g%0h d%h", i, wr_en, grant_id, wr_data, exp_aux, exp_data);
                end
            end
        end
        cpu_valid = 1'b0; aux_valid = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b1 || grant_id !== 1'b1 || wr_addr !== 32'h84) begin
            failures++; $display("FAIL contend_drain got=en%0h g%0h a%h exp=en1 g1 a84", wr_en, grant_id, wr_addr);
        end
        tick();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL contend_idle got=en%0h b%0h exp=en0 b0", wr_en, busy);
        end
    endtask

    task automatic test_out_of_window();
        logic [31:0] oow [5];
        logic [1:0]  exp_d2;
        oow = '{32'h88, 32'h7C, 32'h88, 32'h100, 32'h7C};
        for (int k = 0; k < 5; k++) begin
            aux_valid = 1'b1; aux_addr = oow[k]; aux_data = 32'hDEAD0000 + 32'(k);
            tick();
            aux_valid = 1'b0;
            tick();
            exp_d2 = (k >= 2) ? 2'd3 : 2'(k + 1);
            checks++; if (wr_en !== 1'b0 || grant_id !== 1'b1) begin
                failures++; $display("FAIL oow_%0d_strobe got=en%0h g%0h exp=en0 g1", k, wr_en, grant_id);
            end
            checks++; if (drop_cnt !== 8'(k + 1)) begin
                failures++; $display("FAIL oow_%0d_drop got=%0d exp=%0d", k, drop_cnt, k + 1);
            end
            checks++; if (d2_drop_cnt !== exp_d2) begin
                failures++; $display("FAIL oow_%0d_drop_sat got=%0d exp=%0d", k, d2_drop_cnt, exp_d2);
            end
            checks++; if (wr_addr !== 32'h84 || wr_data !== 32'h2222) begin
                failures++; $display("FAIL oow_%0d_hold got=%h/%h exp=84/2222", k, wr_addr, wr_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        aux_valid = 1'b1; aux_addr = 32'h80; aux_data = 32'h77;
        tick();
        aux_valid = 1'b0; clm = 1'b1;
        tick();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_rst got=en%0h b%0h exp=en0 b0", wr_en, busy);
        end
        clm = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL mid_no_write got=%0h exp=0", wr_en); end
        checks++; if (aux_ready !== 1'b1) begin failures++; $display("FAIL mid_aux_ready got=%0h exp=1", aux_ready); end
        checks++; if (drop_cnt !== 8'd0 || d2_drop_cnt !== 2'd0) begin
            failures++; $display("FAIL mid_drop got=%0d/%0d exp=0/0", drop_cnt, d2_drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_single();
        test_passthrough();
        test_tie();
        test_contention();
        test_out_of_window();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
